// File: rtl/user_id_capture.sv
// user_id_capture: captures an ID_W-bit user ID from serial stream x after a
// detector pulse on y, and queues completed IDs in a first-word-fall-through FIFO.
// Optional macro PARITY_CHECK_EN adds one even-parity bit after the payload;
// IDs with bad parity are dropped and the sticky parity_err output is set.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   x, y            serial data bit, detector start pulse
//   id_data/valid   FIFO head (registered), id_ready pops it
//   fifo_count      number of stored IDs
//   overflow        sticky, a completed ID was dropped because the FIFO was full
//   busy            capture in progress
//   parity_err      (PARITY_CHECK_EN only) sticky parity mismatch flag
module user_id_capture #(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x,
  input  logic                       y,
  output logic [ID_W-1:0]            id_data,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       busy
`ifdef PARITY_CHECK_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int unsigned CNT_W  = $clog2(ID_W + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PARITY_CHECK_EN
    ,
    PAR   = 2'd2
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     shift_q, shift_d;
  logic [ID_W-1:0]     mem_q [DEPTH];
  logic [ID_W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic [ID_W-1:0]     id_data_q, id_data_d;
  logic                id_valid_q, id_valid_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
`ifdef PARITY_CHECK_EN
  logic                parity_err_q, parity_err_d;
`endif

  logic                commit;
  logic                push;
  logic                pop;

  // Capture FSM: next state, shift register, bit counter, commit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    commit  = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (y) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shift_d = ID_W'({shift_q, x});
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ID_W - 1)) begin
`ifdef PARITY_CHECK_EN
          state_d = PAR;
`else
          state_d = IDLE;
          commit  = 1'b1;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        // Even parity: payload bits plus parity bit must XOR to zero.
        state_d = IDLE;
        if (^{shift_q, x} == 1'b0) begin
          commit = 1'b1;
        end else begin
          parity_err_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO update; a full FIFO still accepts a commit when the head pops on the same edge.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop        = id_valid_q & id_ready;
    push       = commit & ((count_q < FCNT_W'(DEPTH)) | pop);
    overflow_d = overflow_q | (commit & ~push);
    if (push) begin
      mem_d[wr_ptr_q] = shift_d;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
    id_valid_d = (count_d != '0);
    id_data_d  = id_valid_d ? mem_d[rd_ptr_d] : '0;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_data_q  <= '0;
      id_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_data_q  <= id_data_d;
      id_valid_q <= id_valid_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      mem_q      <= mem_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign id_data    = id_data_q;
  assign id_valid   = id_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_user_id_capture.sv
// Randomized and directed bench for user_id_capture against a queue-based model.
module tb_user_id_capture;

  localparam int unsigned ID_W  = 8;
  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   x = 1'b0;
  logic                   y = 1'b0;
  logic                   id_ready = 1'b0;
  logic [ID_W-1:0]        id_data;
  logic                   id_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   busy;
`ifdef PARITY_CHECK_EN
  logic                   parity_err;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: payload accumulation and a queue of stored IDs.
  bit m_busy;
  int m_n;
  int m_val;
  int q[$];
  bit m_ovf;
  bit m_perr;

  user_id_capture #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .id_data(id_data), .id_valid(id_valid), .id_ready(id_ready),
    .fifo_count(fifo_count), .overflow(overflow), .busy(busy)
`ifdef PARITY_CHECK_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_n = 0; m_val = 0; m_ovf = 0; m_perr = 0;
    q.delete();
  endtask

  // One clock edge of the specified behaviour, evaluated on the inputs seen at that edge.
  task automatic model_step(input bit yi, input bit xi, input bit ri);
    bit pop;
    bit cmt;
    pop = (q.size() != 0) && ri;
    cmt = 0;
    if (m_busy) begin
      if (m_n < int'(ID_W)) begin
        m_val = (m_val * 2 + int'(xi)) % (1 << ID_W);
        m_n++;
`ifndef PARITY_CHECK_EN
        if (m_n == int'(ID_W)) begin
          cmt = 1;
          m_busy = 0;
        end
`endif
      end else begin
        m_busy = 0;
        if ((($countones(m_val) + int'(xi)) % 2) == 0) cmt = 1;
        else m_perr = 1;
      end
    end else if (yi) begin
      m_busy = 1;
      m_n = 0;
      m_val = 0;
    end
    if (pop) void'(q.pop_front());
    if (cmt) begin
      if (q.size() < int'(DEPTH)) q.push_back(m_val);
      else m_ovf = 1;
    end
  endtask

  task automatic check_outputs();
    check("valid", 32'(id_valid), 32'(q.size() != 0));
    check("data", 32'(id_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("count", 32'(fifo_count), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'(m_busy));
`ifdef PARITY_CHECK_EN
    check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic step(input bit yi, input bit xi, input bit ri);
    y = yi; x = xi; id_ready = ri;
    model_step(yi, xi, ri);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    y = 0; x = 0; id_ready = 0;
    rst = 1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // y pulse, then ID_W payload bits MSB-first (plus parity bit when enabled).
  task automatic send_id(input logic [ID_W-1:0] val, input bit r, input bit r_last, input int y_at);
    step(1'b1, 1'($urandom % 2), r);
    for (int i = 0; i < int'(ID_W); i++) begin
`ifdef PARITY_CHECK_EN
      step(i == y_at, val[ID_W-1-i], r);
`else
      step(i == y_at, val[ID_W-1-i], (i == int'(ID_W) - 1) ? r_last : r);
`endif
    end
`ifdef PARITY_CHECK_EN
    step(1'b0, ^val, r_last);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();

    // Single ID 0xB2 appears the cycle after its last bit.
    send_id(8'hB2, 1'b0, 1'b0, -1);
    check("b2_valid", 32'(id_valid), 32'd1);
    check("b2_data", 32'(id_data), 32'hB2);
    check("b2_count", 32'(fifo_count), 32'd1);
    drain();

    // Overflow: five IDs with no consumer, then ordered pops.
    do_reset();
    for (int k = 1; k <= 5; k++) send_id(ID_W'(k), 1'b0, 1'b0, -1);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    for (int k = 1; k <= 4; k++) begin
      check("ovf_order", 32'(id_data), 32'(k));
      step(1'b0, 1'b0, 1'b1);
    end
    check("ovf_empty", 32'(id_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Commit into a full FIFO with a pop on the same edge.
    do_reset();
    for (int k = 1; k <= 4; k++) send_id(ID_W'(k), 1'b0, 1'b0, -1);
    send_id(8'hAA, 1'b0, 1'b1, -1);
    check("full_pop_count", 32'(fifo_count), 32'd4);
    check("full_pop_ovf", 32'(overflow), 32'd0);
    check("full_pop_head", 32'(id_data), 32'h02);
    drain();

    // y during a capture is ignored; one ID committed, then a fresh capture works.
    do_reset();
    send_id(8'h5C, 1'b0, 1'b0, 2);
    check("restart_count", 32'(fifo_count), 32'd1);
    send_id(8'h3E, 1'b0, 1'b0, -1);
    check("restart_count2", 32'(fifo_count), 32'd2);
    drain();

    // Reset mid-capture discards the partial ID.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom % 2), 1'b0);
    do_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'($urandom % 2), 1'b0);
    check("midrst_empty", 32'(fifo_count), 32'd0);

    // Random traffic: sparse y pulses, random data and consumer readiness.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 6) == 0, 1'($urandom % 2), ($urandom % 4) == 0);
      if (i == 1500) do_reset();
    end
    for (int i = 0; i < 1000; i++) begin
      step(($urandom % 3) == 0, 1'($urandom % 2), ($urandom % 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_id_capture.md
USER_ID_CAPTURE -- requirements
Module: user_id_capture

Interface
REQ-001 Parameter ID_W, default 8, payload bits captured per detection.
REQ-002 Parameter DEPTH, default 4, ID FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 x  input  1  serial bit stream, the same stream fed to the upstream pattern detector.
REQ-006 y  input  1  detector pulse; one cycle high marks the start of a payload.
REQ-007 id_data  output  ID_W  head-of-FIFO user ID (first-word-fall-through).
REQ-008 id_valid  output  1  FIFO non-empty.
REQ-009 id_ready  input  1  consumer accepts id_data this cycle.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  stored entries.
REQ-011 overflow  output  1  sticky: a completed ID was dropped.
REQ-012 busy  output  1  capture in progress.

Function
REQ-013 FSM states: IDLE, SHIFT, plus PAR when PARITY_CHECK_EN is defined.
REQ-014 IDLE -> SHIFT on an edge sampling y=1; bit counter cleared; x on that edge is not captured.
REQ-015 SHIFT: each edge shifts x into shift register MSB-first; bit counter +1.
REQ-016 SHIFT -> IDLE (or PAR) on the edge capturing bit ID_W; the completed ID is committed on that same edge.
REQ-017 y sampled while not IDLE is ignored; no restart, no nesting.
REQ-018 busy = (state != IDLE).
REQ-019 Latency: ID visible on id_data/id_valid the cycle after its last bit is sampled, if FIFO was empty.
REQ-020 Pop occurs on an edge with id_valid=1 and id_ready=1; id_ready with id_valid=0 is ignored.
REQ-021 Commit accepted if fifo_count<DEPTH, or if full with a pop on the same edge (count unchanged, order preserved).
REQ-022 Commit with FIFO full and no pop: ID discarded, FIFO untouched, overflow set to 1.
REQ-023 Simultaneous commit and pop when not full or empty: count unchanged; when empty, commit only (no pop possible).
REQ-024 FIFO pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH nor underflows.
REQ-025 overflow clears only by reset.

Reset
REQ-026 rst=1 immediately forces: state IDLE, bit counter 0, shift register 0, FIFO pointers 0, fifo_count 0, id_valid 0, id_data 0, overflow 0, busy 0.
REQ-027 Reset mid-capture discards the partial ID; no commit occurs.
REQ-028 First capture after reset release requires a fresh y pulse.

Configuration
REQ-029 Macro PARITY_CHECK_EN: when defined, after bit ID_W the FSM enters PAR and samples one even-parity bit over the ID.
REQ-030 With PARITY_CHECK_EN: commit on the PAR edge only if parity matches; mismatch drops the ID, adds output parity_err (1 bit, sticky, reset 0), set on mismatch.
REQ-031 Without PARITY_CHECK_EN: no PAR state, no parity_err port, commit per REQ-016.

Verification
REQ-032 Reset, y pulse, then x=1,0,1,1,0,0,1,0 -> id_valid=1 one cycle after last bit, id_data=8'hB2, fifo_count=1.
REQ-033 Five IDs 8'h01..8'h05 with id_ready=0 -> first four stored, fifth dropped, overflow=1, pops return 01,02,03,04 in order.
REQ-034 FIFO full, commit of 8'hAA with id_ready=1 same edge -> 8'h01 popped, 8'hAA appended, fifo_count stays 4, overflow stays 0.
REQ-035 y re-pulsed at bit 3 of a capture -> ignored; exactly one ID committed, then new y starts a fresh capture.
REQ-036 rst asserted after 5 payload bits -> busy=0, fifo_count=0, no ID ever appears.
REQ-037 PARITY_CHECK_EN: ID 8'hB2 with parity 0 -> committed; with parity 1 -> dropped, parity_err=1, fifo_count unchanged.
